// File: rtl/fsic_io_serdes_rx_link_ctrl.sv
// Link bring-up controller for the FSIC IO SERDES RX path: sequences rxen,
// trains on a fixed word pattern and forwards received words once the link is up.
module fsic_io_serdes_rx_link_ctrl #(
    parameter int unsigned              pCLK_RATIO     = 4,
    parameter logic [pCLK_RATIO-1:0]    pTRAIN_PATTERN = 4'hA,
    parameter int unsigned              pTRAIN_CNT     = 8,
    parameter int unsigned              pTIMEOUT       = 64,
    parameter int unsigned              pOFF_CYCLES    = 4,
    parameter int unsigned              pMAX_RETRY     = 3
) (
    input  logic                                coreclk,
    input  logic                                axis_rst_n,
    input  logic                                link_en,
    input  logic [pCLK_RATIO-1:0]               rxdata_in,
    input  logic                                rxdata_in_valid,
    output logic                                rxen,
    output logic                                link_up,
    output logic                                link_fail,
    output logic [pCLK_RATIO-1:0]               rxdata_out,
    output logic                                rxdata_out_valid,
    output logic [$clog2(pMAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int unsigned TMR_W = $clog2(pTIMEOUT);
    localparam int unsigned MCH_W = $clog2(pTRAIN_CNT + 1);
    localparam int unsigned OFF_W = $clog2(pOFF_CYCLES + 1);
    localparam int unsigned RTY_W = $clog2(pMAX_RETRY + 1);

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(pTIMEOUT - 1);
    localparam logic [MCH_W-1:0] MCH_LAST  = MCH_W'(pTRAIN_CNT - 1);
    localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(pOFF_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(pMAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENABLE,
        S_WAIT_VALID,
        S_TRAIN,
        S_RETRY,
        S_LINK_UP,
        S_FAIL
    } state_e;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [MCH_W-1:0]        match_cnt_q, match_cnt_d;
    logic [OFF_W-1:0]        off_cnt_q, off_cnt_d;
    logic [RTY_W-1:0]        retry_cnt_q, retry_cnt_d;
    logic                    rxen_q, rxen_d;
    logic                    link_up_q, link_up_d;
    logic                    link_fail_q, link_fail_d;
    logic [pCLK_RATIO-1:0]   rxdata_out_q, rxdata_out_d;
    logic                    rxdata_out_valid_q, rxdata_out_valid_d;
    logic                    fwd;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        match_cnt_d  = match_cnt_q;
        off_cnt_d    = off_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        rxdata_out_d = rxdata_out_q;

        case (state_q)
            S_IDLE: begin
                if (link_en) state_d = S_ENABLE;
            end
            S_ENABLE: begin
                timer_d = '0;
                state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (rxdata_in_valid) begin
                    state_d     = S_TRAIN;
                    timer_d     = '0;
                    match_cnt_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_RETRY;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_TRAIN: begin
                // A completing match outranks a timeout in the same cycle.
                if (rxdata_in == pTRAIN_PATTERN) begin
                    if (match_cnt_q == MCH_LAST) state_d = S_LINK_UP;
                    else                         match_cnt_d = match_cnt_q + 1'b1;
                end else begin
                    match_cnt_d = '0;
                end
                if (state_d != S_LINK_UP) begin
                    if (timer_q == TMR_LAST) state_d = S_RETRY;
                    else                     timer_d = timer_q + 1'b1;
                end
            end
            S_RETRY: begin
                if (off_cnt_q == OFF_LAST) begin
                    state_d = (retry_cnt_q == RTY_LIMIT) ? S_FAIL : S_ENABLE;
                end else begin
                    off_cnt_d = off_cnt_q + 1'b1;
                end
            end
            S_LINK_UP: begin
                if (!rxdata_in_valid) state_d = S_RETRY;
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !link_en) state_d = S_IDLE;

        if (state_d == S_RETRY && state_q != S_RETRY) begin
            off_cnt_d   = '0;
            retry_cnt_d = (retry_cnt_q == RTY_LIMIT) ? retry_cnt_q : retry_cnt_q + 1'b1;
        end
        if (state_d == S_IDLE || state_d == S_LINK_UP) retry_cnt_d = '0;

        // Outputs are registered against the next state so they line up with it.
        rxen_d      = (state_d == S_WAIT_VALID) || (state_d == S_TRAIN) || (state_d == S_LINK_UP);
        link_up_d   = (state_d == S_LINK_UP);
        link_fail_d = (state_d == S_FAIL);

        fwd                = (state_q == S_LINK_UP) && (state_d == S_LINK_UP);
        rxdata_out_valid_d = fwd;
        if (fwd) rxdata_out_d = rxdata_in;
    end

    always_ff @(posedge coreclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q            <= S_IDLE;
            timer_q            <= '0;
            match_cnt_q        <= '0;
            off_cnt_q          <= '0;
            retry_cnt_q        <= '0;
            rxen_q             <= 1'b0;
            link_up_q          <= 1'b0;
            link_fail_q        <= 1'b0;
            rxdata_out_q       <= '0;
            rxdata_out_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            timer_q            <= timer_d;
            match_cnt_q        <= match_cnt_d;
            off_cnt_q          <= off_cnt_d;
            retry_cnt_q        <= retry_cnt_d;
            rxen_q             <= rxen_d;
            link_up_q          <= link_up_d;
            link_fail_q        <= link_fail_d;
            rxdata_out_q       <= rxdata_out_d;
            rxdata_out_valid_q <= rxdata_out_valid_d;
        end
    end

    assign rxen             = rxen_q;
    assign link_up          = link_up_q;
    assign link_fail        = link_fail_q;
    assign rxdata_out       = rxdata_out_q;
    assign rxdata_out_valid = rxdata_out_valid_q;
    assign retry_cnt        = retry_cnt_q;

endmodule

// File: tb/tb_fsic_io_serdes_rx_link_ctrl.sv
// Directed bench for fsic_io_serdes_rx_link_ctrl: bring-up, training faults,
// timeouts/retries, loss of valid, coincident events and async reset.
module tb_fsic_io_serdes_rx_link_ctrl;

    logic       coreclk;
    logic       axis_rst_n;
    logic       link_en;
    logic [3:0] rxdata_in;
    logic       rxdata_in_valid;
    logic       rxen;
    logic       link_up;
    logic       link_fail;
    logic [3:0] rxdata_out;
    logic       rxdata_out_valid;
    logic [1:0] retry_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fsic_io_serdes_rx_link_ctrl #(
        .pCLK_RATIO     (4),
        .pTRAIN_PATTERN (4'hA),
        .pTRAIN_CNT     (8),
        .pTIMEOUT       (64),
        .pOFF_CYCLES    (4),
        .pMAX_RETRY     (3)
    ) dut (
        .coreclk          (coreclk),
        .axis_rst_n       (axis_rst_n),
        .link_en          (link_en),
        .rxdata_in        (rxdata_in),
        .rxdata_in_valid  (rxdata_in_valid),
        .rxen             (rxen),
        .link_up          (link_up),
        .link_fail        (link_fail),
        .rxdata_out       (rxdata_out),
        .rxdata_out_valid (rxdata_out_valid),
        .retry_cnt        (retry_cnt)
    );

    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge coreclk);
    endtask

    // From IDLE: leaves the DUT in its first TRAIN cycle.
    task automatic bring_to_train();
        link_en         = 1'b1;
        rxdata_in_valid = 1'b1;
        rxdata_in       = 4'h0;
        tick();
        tick();
        tick();
    endtask

    task automatic send_train(input int unsigned n, input logic [3:0] w);
        for (int unsigned i = 0; i < n; i++) begin
            rxdata_in = w;
            tick();
            chk("train_no_linkup", 32'(link_up), 32'd0);
            chk("train_no_fwd", 32'(rxdata_out_valid), 32'd0);
        end
    endtask

    initial begin
        axis_rst_n      = 1'b0;
        link_en         = 1'b0;
        rxdata_in       = 4'h0;
        rxdata_in_valid = 1'b0;
        tick();
        tick();
        chk("rst_rxen", 32'(rxen), 32'd0);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_link_fail", 32'(link_fail), 32'd0);
        chk("rst_rxdata_out", 32'(rxdata_out), 32'd0);
        chk("rst_out_valid", 32'(rxdata_out_valid), 32'd0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        axis_rst_n = 1'b1;
        tick();

        // Clean bring-up
        link_en = 1'b1;
        tick();
        chk("enable_rxen_low", 32'(rxen), 32'd0);
        tick();
        chk("wait_rxen_high", 32'(rxen), 32'd1);
        repeat (9) tick();
        rxdata_in_valid = 1'b1;
        tick();
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        chk("clean_link_up", 32'(link_up), 32'd1);
        chk("clean_retry_cnt", 32'(retry_cnt), 32'd0);
        chk("clean_no_fwd_yet", 32'(rxdata_out_valid), 32'd0);
        chk("clean_rxen", 32'(rxen), 32'd1);
        rxdata_in = 4'h3;
        tick();
        chk("fwd_word0", 32'(rxdata_out), 32'h3);
        chk("fwd_valid0", 32'(rxdata_out_valid), 32'd1);
        rxdata_in = 4'h5;
        tick();
        chk("fwd_word1", 32'(rxdata_out), 32'h5);
        chk("fwd_valid1", 32'(rxdata_out_valid), 32'd1);
        rxdata_in = 4'h7;
        link_en   = 1'b0;
        tick();
        chk("drop_rxen", 32'(rxen), 32'd0);
        chk("drop_link_up", 32'(link_up), 32'd0);
        chk("drop_out_valid", 32'(rxdata_out_valid), 32'd0);
        chk("drop_out_hold", 32'(rxdata_out), 32'h5);

        // Broken training: mismatch restarts the match count
        bring_to_train();
        send_train(5, 4'hA);
        send_train(1, 4'h0);
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        chk("broken_link_up", 32'(link_up), 32'd1);
        link_en = 1'b0;
        tick();

        // Valid timeout, three retries, then FAIL
        rxdata_in_valid = 1'b0;
        link_en         = 1'b1;
        tick();
        for (int unsigned a = 1; a <= 3; a++) begin
            tick();
            chk("to_wait_start", 32'(rxen), 32'd1);
            repeat (63) tick();
            chk("to_wait_last", 32'(rxen), 32'd1);
            tick();
            chk("to_retry_rxen", 32'(rxen), 32'd0);
            chk("to_retry_cnt", 32'(retry_cnt), 32'(a));
            chk("to_retry_nofail", 32'(link_fail), 32'd0);
            repeat (3) tick();
            chk("to_retry_off_rxen", 32'(rxen), 32'd0);
            tick();
            if (a < 3) begin
                chk("to_enable_rxen", 32'(rxen), 32'd0);
                chk("to_enable_nofail", 32'(link_fail), 32'd0);
            end
        end
        chk("fail_flag", 32'(link_fail), 32'd1);
        chk("fail_rxen", 32'(rxen), 32'd0);
        chk("fail_retry_cnt", 32'(retry_cnt), 32'd3);
        repeat (5) tick();
        chk("fail_sticky", 32'(link_fail), 32'd1);
        link_en = 1'b0;
        tick();
        chk("fail_clear_flag", 32'(link_fail), 32'd0);
        chk("fail_clear_retry", 32'(retry_cnt), 32'd0);

        // Loss of valid while up
        bring_to_train();
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        chk("lov_link_up", 32'(link_up), 32'd1);
        rxdata_in = 4'h9;
        tick();
        chk("lov_fwd_word", 32'(rxdata_out), 32'h9);
        rxdata_in_valid = 1'b0;
        tick();
        chk("lov_link_up_low", 32'(link_up), 32'd0);
        chk("lov_out_valid_low", 32'(rxdata_out_valid), 32'd0);
        chk("lov_retry_cnt", 32'(retry_cnt), 32'd1);
        chk("lov_rxen_low", 32'(rxen), 32'd0);
        link_en = 1'b0;
        tick();
        chk("lov_idle_retry", 32'(retry_cnt), 32'd0);

        // Timeout during TRAIN
        bring_to_train();
        send_train(63, 4'h0);
        chk("ttrain_still_rxen", 32'(rxen), 32'd1);
        rxdata_in = 4'h0;
        tick();
        chk("ttrain_retry_rxen", 32'(rxen), 32'd0);
        chk("ttrain_retry_cnt", 32'(retry_cnt), 32'd1);
        link_en = 1'b0;
        tick();

        // Final match coincides with timer expiry
        bring_to_train();
        send_train(56, 4'h0);
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        chk("coinc_link_up", 32'(link_up), 32'd1);
        chk("coinc_retry_cnt", 32'(retry_cnt), 32'd0);
        link_en = 1'b0;
        tick();

        // link_en drop coincides with final match
        bring_to_train();
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        link_en   = 1'b0;
        tick();
        chk("endrop_link_up", 32'(link_up), 32'd0);
        chk("endrop_rxen", 32'(rxen), 32'd0);
        tick();
        chk("endrop_link_up2", 32'(link_up), 32'd0);

        // Async reset mid-TRAIN
        bring_to_train();
        send_train(3, 4'hA);
        #2;
        axis_rst_n = 1'b0;
        link_en    = 1'b0;
        #1;
        chk("arst_train_rxen", 32'(rxen), 32'd0);
        chk("arst_train_retry", 32'(retry_cnt), 32'd0);
        tick();
        axis_rst_n = 1'b1;
        tick();

        // Async reset mid-LINK_UP
        bring_to_train();
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        rxdata_in = 4'h6;
        tick();
        chk("arst_pre_word", 32'(rxdata_out), 32'h6);
        chk("arst_pre_valid", 32'(rxdata_out_valid), 32'd1);
        #2;
        axis_rst_n = 1'b0;
        link_en    = 1'b0;
        #1;
        chk("arst_up_link_up", 32'(link_up), 32'd0);
        chk("arst_up_valid", 32'(rxdata_out_valid), 32'd0);
        chk("arst_up_word", 32'(rxdata_out), 32'h0);
        chk("arst_up_rxen", 32'(rxen), 32'd0);
        tick();
        axis_rst_n = 1'b1;
        tick();

        // Fresh bring-up after reset
        bring_to_train();
        send_train(7, 4'hA);
        rxdata_in = 4'hA;
        tick();
        chk("fresh_link_up", 32'(link_up), 32'd1);
        rxdata_in = 4'hC;
        tick();
        chk("fresh_word", 32'(rxdata_out), 32'hC);
        chk("fresh_valid", 32'(rxdata_out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
